// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and the data memory.
// Stores retire into a circular buffer and drain one per cycle whenever no load
// owns the memory address port. Loads search the buffer youngest-first: a fully
// covering store forwards its data, a partial overlap stalls the load.
// Optional build macro: STORE_BUF_FORWARD_EN enables store-to-load forwarding.
// Without it, ld_hit and ld_data are tied to 0 and any overlap stalls the load.
module store_buffer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic                       st_byte,
  input  logic [ADDRESS_WIDTH-1:0]   st_addr,
  input  logic [DATA_WIDTH-1:0]      st_data,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic                       ld_byte,
  input  logic [ADDRESS_WIDTH-1:0]   ld_addr,
  output logic                       ld_hit,
  output logic [DATA_WIDTH-1:0]      ld_data,
  output logic                       ld_stall,
  output logic                       mem_we,
  output logic                       mem_addr_mode,
  output logic [ADDRESS_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wd,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDRESS_WIDTH-1:0] BYTE_SPAN = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_SPAN = ADDRESS_WIDTH'(4);

  typedef struct packed {
    logic                     is_byte;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } entry_t;

  entry_t             ent [DEPTH];
  logic [DEPTH-1:0]   ent_valid;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   cnt;
  logic               push;
  logic               pop;
  logic               hit_found;
  logic [PTR_W-1:0]   hit_idx;

  // Handshake and drain: the memory port is free only when no load is presented.
  assign st_ready      = (cnt != CNT_W'(DEPTH));
  assign push          = st_valid && st_ready;
  assign mem_we        = (cnt != '0) && !ld_valid;
  assign pop           = mem_we;
  assign mem_addr_mode = ent[head].is_byte;
  assign mem_addr      = ent[head].addr;
  assign mem_wd        = ent[head].data;
  assign count         = cnt;

  // Pointer and occupancy update; simultaneous push and pop leaves cnt unchanged.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values and the block order cannot create a race.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage: write the pushed store at tail, retire the head on drain.
  // NOTE: the entry array is reset because mem_* expose the head entry directly
  // and must read as zero out of reset; a storage array not visible at the ports
  // would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      ent_valid <= '0;
    end else begin
      if (pop) ent_valid[head] <= 1'b0;
      if (push) begin
        ent[tail]       <= '{is_byte: st_byte, addr: st_addr, data: st_data};
        ent_valid[tail] <= 1'b1;
      end
    end
  end

  // Overlap search from oldest to youngest; the last match is the youngest.
  // Spans are compared via modular differences so address wrap is handled.
  // NOTE: every combinational output gets a default at the top of the block so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin : search
    logic [PTR_W-1:0]         idx;
    logic [ADDRESS_WIDTH-1:0] d_la;
    logic [ADDRESS_WIDTH-1:0] d_al;
    logic                     ovl;
    hit_found = 1'b0;
    hit_idx   = '0;
    idx       = '0;
    d_la      = '0;
    d_al      = '0;
    ovl       = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx  = head + PTR_W'(k);
      d_la = ld_addr - ent[idx].addr;
      d_al = ent[idx].addr - ld_addr;
      ovl  = (d_la < (ent[idx].is_byte ? BYTE_SPAN : WORD_SPAN)) ||
             (d_al < (ld_byte ? BYTE_SPAN : WORD_SPAN));
      if (ent_valid[idx] && ovl) begin
        hit_found = 1'b1;
        hit_idx   = idx;
      end
    end
  end

`ifdef STORE_BUF_FORWARD_EN
  logic [ADDRESS_WIDTH-1:0] sel_off;
  logic                     sel_cover;
  logic [7:0]               sel_byte;

  // Full-cover test and byte extraction for the selected (youngest) entry.
  always_comb begin
    sel_off = ld_addr - ent[hit_idx].addr;
    if (ent[hit_idx].is_byte)
      sel_cover = ld_byte && (sel_off == '0);
    else if (ld_byte)
      sel_cover = (sel_off < WORD_SPAN);
    else
      sel_cover = (sel_off == '0);
    sel_byte = ent[hit_idx].data[8*sel_off[1:0] +: 8];
  end

  // Forward on full cover, stall on partial overlap, silent otherwise.
  always_comb begin
    ld_hit   = 1'b0;
    ld_stall = 1'b0;
    ld_data  = '0;
    if (ld_valid && hit_found) begin
      if (sel_cover) begin
        ld_hit  = 1'b1;
        ld_data = ld_byte ? DATA_WIDTH'(sel_byte) : ent[hit_idx].data;
      end else begin
        ld_stall = 1'b1;
      end
    end
  end
`else
  // No forwarding: any overlap with a pending store holds the load.
  always_comb begin
    ld_hit   = 1'b0;
    ld_data  = '0;
    ld_stall = ld_valid && hit_found;
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer (DEPTH=4).
// Expectations follow the forwarding build when STORE_BUF_FORWARD_EN is defined,
// and the stall-on-any-overlap build otherwise.
module tb_store_buffer;

`ifdef STORE_BUF_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_byte;
  logic [31:0] st_addr, st_data;
  logic        st_ready;
  logic        ld_valid, ld_byte;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic        mem_we, mem_addr_mode;
  logic [31:0] mem_addr, mem_wd;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  store_buffer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_byte(st_byte), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_we(mem_we), .mem_addr_mode(mem_addr_mode), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic b, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_byte  = b;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic load(input logic b, input logic [31:0] a);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_addr  = a;
  endtask

  initial begin
    rst_n = 1'b0;
    st_valid = 1'b0; st_byte = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_byte = 1'b0; ld_addr = '0;

    // 1: reset state
    #3;
    check("rst_st_ready", st_ready, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_count", count, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_ld_stall", ld_stall, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("idle_count", count, 0);
    check("idle_mem_we", mem_we, 0);

    // 2: single word store drains the cycle after it is accepted
    store(1'b0, 32'h0001_0000, 32'hDEAD_BEEF);
    tick();
    st_valid = 1'b0;
    #1;
    check("t2_count1", count, 1);
    check("t2_mem_we", mem_we, 1);
    check("t2_mem_addr", mem_addr, 32'h0001_0000);
    check("t2_mem_wd", mem_wd, 32'hDEAD_BEEF);
    check("t2_mode", mem_addr_mode, 0);
    tick();
    check("t2_count0", count, 0);
    check("t2_mem_we0", mem_we, 0);

    // 3: fill while a far load blocks draining, reject 5th push, drain in order
    load(1'b0, 32'h0002_0000);
    for (int i = 0; i < 4; i++) begin
      store(1'b0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      tick();
    end
    store(1'b0, 32'h200, 32'hBAD);
    #1;
    check("t3_full_count", count, 4);
    check("t3_st_ready", st_ready, 0);
    check("t3_blocked_we", mem_we, 0);
    check("t3_far_hit", ld_hit, 0);
    check("t3_far_stall", ld_stall, 0);
    tick();
    check("t3_5th_ignored", count, 4);
    st_valid = 1'b0;
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_drain_we", mem_we, 1);
      check("t3_drain_addr", mem_addr, 32'h100 + 32'(4 * i));
      check("t3_drain_wd", mem_wd, 32'hA0 + 32'(i));
      check("t3_drain_count", count, 32'(4 - i));
      tick();
    end
    check("t3_empty", count, 0);

    // 4: byte-from-word forward, partial overlaps, byte store shadowing a word
    load(1'b0, 32'h0002_0000);
    store(1'b0, 32'h0001_0004, 32'h1122_3344);
    tick();
    st_valid = 1'b0;
    load(1'b1, 32'h0001_0006);
    #1;
    check("t4_bw_hit", ld_hit, FWD);
    check("t4_bw_data", ld_data, FWD ? 32'h22 : 32'h0);
    check("t4_bw_stall", ld_stall, !FWD);
    load(1'b0, 32'h0001_0004);
    #1;
    check("t4_ww_hit", ld_hit, FWD);
    check("t4_ww_data", ld_data, FWD ? 32'h1122_3344 : 32'h0);
    load(1'b0, 32'h0001_0002);
    #1;
    check("t4_part_stall", ld_stall, 1);
    check("t4_part_hit", ld_hit, 0);
    load(1'b0, 32'h0002_0000);
    store(1'b1, 32'h0001_0004, 32'h0000_00AA);
    tick();
    st_valid = 1'b0;
    load(1'b0, 32'h0001_0004);
    #1;
    check("t4_wb_stall", ld_stall, 1);
    check("t4_wb_hit", ld_hit, 0);
    load(1'b1, 32'h0001_0004);
    #1;
    check("t4_bb_data", ld_data, FWD ? 32'hAA : 32'h0);
    check("t4_bb_stall", ld_stall, !FWD);
    load(1'b1, 32'h0001_0005);
    #1;
    check("t4_b5_data", ld_data, FWD ? 32'h33 : 32'h0);
    ld_valid = 1'b0;
    #1;
    check("t4_noload_data", ld_data, 0);
    check("t4_d1_mode", mem_addr_mode, 0);
    tick();
    check("t4_d2_mode", mem_addr_mode, 1);
    check("t4_d2_addr", mem_addr, 32'h0001_0004);
    check("t4_d2_wd", mem_wd, 32'hAA);
    tick();
    check("t4_empty", count, 0);

    // address wrap: word at 0xFFFFFFFE covers byte 0x00000001
    load(1'b0, 32'h0002_0000);
    store(1'b0, 32'hFFFF_FFFE, 32'h5566_7788);
    tick();
    st_valid = 1'b0;
    load(1'b1, 32'h0000_0001);
    #1;
    check("wrap_b_data", ld_data, FWD ? 32'h55 : 32'h0);
    check("wrap_b_stall", ld_stall, !FWD);
    load(1'b0, 32'h0000_0002);
    #1;
    check("wrap_w_stall", ld_stall, 0);
    check("wrap_w_hit", ld_hit, 0);
    ld_valid = 1'b0;
    tick();
    check("wrap_empty", count, 0);

    // 5: youngest of two byte stores wins
    load(1'b0, 32'h0002_0000);
    store(1'b1, 32'h0001_0000, 32'h01);
    tick();
    store(1'b1, 32'h0001_0000, 32'h02);
    tick();
    st_valid = 1'b0;
    load(1'b1, 32'h0001_0000);
    #1;
    check("t5_data", ld_data, FWD ? 32'h02 : 32'h0);
    check("t5_hit", ld_hit, FWD);
    ld_valid = 1'b0;
    tick();
    tick();
    check("t5_empty", count, 0);

    // 6: push and drain on the same edge at count=2, wrapping both pointers
    load(1'b0, 32'h0002_0000);
    for (int i = 0; i < 2; i++) begin
      store(1'b0, 32'h300 + 32'(4 * i), 32'h600 + 32'(i));
      tick();
    end
    ld_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      store(1'b0, 32'h300 + 32'(4 * (j + 2)), 32'h600 + 32'(j + 2));
      #1;
      check("t6_addr", mem_addr, 32'h300 + 32'(4 * j));
      check("t6_wd", mem_wd, 32'h600 + 32'(j));
      tick();
      check("t6_count", count, 2);
    end
    st_valid = 1'b0;
    #1;
    check("t6_tail0", mem_addr, 32'h310);
    tick();
    check("t6_tail1", mem_addr, 32'h314);
    tick();
    check("t6_empty", count, 0);

    // reset in the middle of draining discards everything
    load(1'b0, 32'h0002_0000);
    store(1'b0, 32'h400, 32'h1);
    tick();
    store(1'b0, 32'h404, 32'h2);
    tick();
    st_valid = 1'b0;
    ld_valid = 1'b0;
    #1;
    check("mr_we_before", mem_we, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mr_we", mem_we, 0);
    check("mr_count", count, 0);
    check("mr_addr", mem_addr, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("mr_after", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
